// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point datapath configuration: Q-format widths, multiplier pipeline depth,
// lane count and the rounding-mode encoding used by the scale/saturate stage.
package fpga_cfg_pkg;

  localparam int FP_WIDTH       = 16;
  localparam int FP_QINT        = 7;
  localparam int FP_QFRAC       = 8;
  localparam int FP_MUL_LATENCY = 3;
  localparam int FP_MUL_LANES   = 2;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } fx_rnd_e;

endpackage

// File: rtl/fx_scale_sat.sv
// Rescales a double-width signed product to Q(QINT.QFRAC), with optional round-half-up and saturation.
// Purely combinational (0 cycles); no handshake, so the caller owns any backpressure.
module fx_scale_sat
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               rnd_mode,
  input  logic               sat_en,
  output logic [WIDTH-1:0]   result,
  output logic               ovf
);

  localparam logic [2*WIDTH:0] RND_ADD = {{(2*WIDTH){1'b0}}, 1'b1} << (QFRAC - 1);

  logic [2*WIDTH:0] t;
  logic [2*WIDTH:0] s;
  logic [WIDTH+1:0] hi;
  logic             pos_ovf;
  logic             neg_ovf;

  always_comb begin
    t = {raw[2*WIDTH-1], raw} + ((rnd_mode == RND_HALF_UP) ? RND_ADD : '0);
    s = $signed(t) >>> QFRAC;
    // In range only if every bit from the result sign bit upward agrees.
    hi      = s[2*WIDTH:WIDTH-1];
    pos_ovf = !hi[WIDTH+1] && (|hi);
    neg_ovf = hi[WIDTH+1] && !(&hi);
    ovf     = pos_ovf || neg_ovf;
    result  = s[WIDTH-1:0];
    if (sat_en && pos_ovf) begin
      result = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (sat_en && neg_ovf) begin
      result = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fx_mul_lanes.sv
// LANES-wide signed fixed-point multiplier with per-beat rounding/saturation and overflow flags, LATENCY cycles.
// Valid/ready per stage; empty stages keep filling under a stall, so bubbles collapse and the output holds.
module fx_mul_lanes
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int QINT    = FP_QINT,
  parameter int QFRAC   = FP_QFRAC,
  parameter int LATENCY = FP_MUL_LATENCY,
  parameter int LANES   = FP_MUL_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   rnd_mode,
  input  logic                   sat_en,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       ovf_out,
  input  logic                   clr_ovf,
  output logic [LANES-1:0]       ovf_sticky
);

  if (QINT + QFRAC + 1 != WIDTH) begin : g_bad_qfmt
    $error("fx_mul_lanes: QINT + QFRAC + 1 must equal WIDTH");
  end
  if (QFRAC < 1) begin : g_bad_qfrac
    $error("fx_mul_lanes: QFRAC must be at least 1");
  end
  if (LATENCY < 2) begin : g_bad_latency
    $error("fx_mul_lanes: LATENCY must be at least 2");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("fx_mul_lanes: LANES must be at least 1");
  end

  logic [LATENCY-1:0]     v;
  logic [LATENCY-1:0]     adv;

  logic [LANES*WIDTH-1:0] a_s0;
  logic [LANES*WIDTH-1:0] b_s0;
  logic                   rnd_s0;
  logic                   sat_s0;

  logic [LANES*WIDTH-1:0] res_q [1:LATENCY-1];
  logic [LANES-1:0]       ovf_q [1:LATENCY-1];

  logic [LANES*WIDTH-1:0] lane_res;
  logic [LANES-1:0]       lane_ovf;

  // A stage may advance when it is empty or everything downstream of it advances.
  always_comb begin
    adv = '0;
    adv[LATENCY-1] = !v[LATENCY-1] || ready_in;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;
    logic signed [2*WIDTH-1:0] raw;

    assign op_a = a_s0[i*WIDTH +: WIDTH];
    assign op_b = b_s0[i*WIDTH +: WIDTH];
    assign raw  = op_a * op_b;

    fx_scale_sat #(
      .WIDTH (WIDTH),
      .QFRAC (QFRAC)
    ) u_scale_sat (
      .raw      (raw),
      .rnd_mode (rnd_s0),
      .sat_en   (sat_s0),
      .result   (lane_res[i*WIDTH +: WIDTH]),
      .ovf      (lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      a_s0   <= '0;
      b_s0   <= '0;
      rnd_s0 <= 1'b0;
      sat_s0 <= 1'b0;
      for (int k = 1; k < LATENCY; k++) begin
        res_q[k] <= '0;
        ovf_q[k] <= '0;
      end
      ovf_sticky <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= valid_in;
        if (valid_in) begin
          a_s0   <= a;
          b_s0   <= b;
          rnd_s0 <= rnd_mode;
          sat_s0 <= sat_en;
        end
      end
      if (adv[1]) begin
        v[1] <= v[0];
        if (v[0]) begin
          res_q[1] <= lane_res;
          ovf_q[1] <= lane_ovf;
        end
      end
      for (int k = 2; k < LATENCY; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
      // Per bit, a new overflow on a delivered beat beats a simultaneous clear.
      ovf_sticky <= (clr_ovf ? '0 : ovf_sticky) |
                    ((v[LATENCY-1] && ready_in) ? ovf_q[LATENCY-1] : '0);
    end
  end

  assign ready_out = adv[0];
  assign valid_out = v[LATENCY-1];
  assign result    = res_q[LATENCY-1];
  assign ovf_out   = ovf_q[LATENCY-1];

endmodule

// File: tb/tb_fx_mul_lanes.sv
// Directed bench for fx_mul_lanes at WIDTH=16, QFRAC=8, LATENCY=3, LANES=2:
// table of hand-computed products plus stall, bubble, sticky and reset sequences.
module tb_fx_mul_lanes;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] a;
  logic [31:0] b;
  logic        rnd_mode;
  logic        sat_en;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic [1:0]  ovf_out;
  logic        clr_ovf;
  logic [1:0]  ovf_sticky;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [15:0] a0, b0, a1, b1;
    logic        rnd, sat;
    logic [15:0] r0, r1;
    logic [1:0]  ovf;
  } vec_t;

  vec_t vt [9];

  fx_mul_lanes #(
    .WIDTH   (16),
    .QINT    (7),
    .QFRAC   (8),
    .LATENCY (3),
    .LANES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .a          (a),
    .b          (b),
    .rnd_mode   (rnd_mode),
    .sat_en     (sat_en),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result     (result),
    .ovf_out    (ovf_out),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one beat for one cycle, then wait (bounded) for it at the output.
  task automatic send_vec(input vec_t v, output int lat);
    valid_in = 1'b1;
    a        = {v.a1, v.a0};
    b        = {v.b1, v.b0};
    rnd_mode = v.rnd;
    sat_en   = v.sat;
    step();
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic run_stream(input int n, input logic [15:0] base, input logic [63:0] idle_mask,
                            input int stall, input int exp_acc, input string tag);
    int   sent, rcv, acc_stall, dup;
    logic acc, hs, hold_prev;
    logic [31:0] res_prev;
    logic [15:0] want;
    sent = 0; rcv = 0; acc_stall = 0; hold_prev = 1'b0; res_prev = '0;
    rnd_mode = 1'b0;
    sat_en   = 1'b1;
    b        = {16'h0100, 16'h0100};
    for (int cyc = 0; cyc < 400 && rcv < n; cyc++) begin
      ready_in = (cyc < stall) ? 1'b0 : cyc[0];
      valid_in = (sent < n) && !((cyc < 64) && idle_mask[cyc[5:0]]);
      want     = 16'(base + 16'(sent));
      a        = {16'(16'h0000 - want), want};
      #4;
      if (hold_prev) begin
        chk({tag, " held valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, " held result"}, result, res_prev);
      end
      acc = valid_in && ready_out;
      hs  = valid_out && ready_in;
      if (cyc < stall && acc) acc_stall++;
      if (cyc == stall - 1) begin
        chk({tag, " accepts under stall"}, acc_stall, exp_acc);
        chk({tag, " ready_out when full"}, {31'd0, ready_out}, 32'd0);
      end
      if (hs) begin
        want = 16'(base + 16'(rcv));
        chk({tag, " lane0 order"}, {16'd0, result[15:0]}, {16'd0, want});
        chk({tag, " lane1 order"}, {16'd0, result[31:16]}, {16'd0, 16'(16'h0000 - want)});
        rcv++;
      end
      hold_prev = valid_out && !ready_in;
      res_prev  = result;
      step();
      if (acc) sent++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    chk({tag, " beats delivered"}, rcv, n);
    dup = 0;
    repeat (5) begin
      if (valid_out) dup++;
      step();
    end
    chk({tag, " no extra beats"}, dup, 0);
  endtask

  initial begin
    int   lat;
    vec_t s_ovf;

    vt[0] = '{16'h0180, 16'h0200, 16'hFF00, 16'h0100, 1'b0, 1'b1, 16'h0300, 16'hFF00, 2'b00};
    vt[1] = '{16'h0001, 16'h0080, 16'hFFFF, 16'h0080, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 2'b00};
    vt[2] = '{16'h0001, 16'h0080, 16'hFFFF, 16'h0080, 1'b1, 1'b1, 16'h0001, 16'h0000, 2'b00};
    vt[3] = '{16'h7F00, 16'h0200, 16'h8000, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 2'b11};
    vt[4] = '{16'h7F00, 16'h0200, 16'h8000, 16'h0200, 1'b0, 1'b0, 16'hFE00, 16'h0000, 2'b11};
    vt[5] = '{16'h4000, 16'h0200, 16'hC000, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 2'b01};
    vt[6] = '{16'h4000, 16'h0200, 16'hC000, 16'h0200, 1'b0, 1'b0, 16'h8000, 16'h8000, 2'b01};
    vt[7] = '{16'h0180, 16'h0180, 16'hFE80, 16'h0180, 1'b1, 1'b1, 16'h0240, 16'hFDC0, 2'b00};
    vt[8] = '{16'h7FFF, 16'h0100, 16'h8000, 16'h0100, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 2'b00};
    s_ovf = '{16'h7F00, 16'h0200, 16'h0100, 16'h0100, 1'b0, 1'b1, 16'h7FFF, 16'h0100, 2'b01};

    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0; rnd_mode = 1'b0; sat_en = 1'b0;
    ready_in = 1'b1; clr_ovf = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset ovf_out", {30'd0, ovf_out}, 32'd0);
    chk("reset ovf_sticky", {30'd0, ovf_sticky}, 32'd0);
    chk("reset ready_out", {31'd0, ready_out}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      send_vec(vt[i], lat);
      chk($sformatf("vec%0d latency", i), lat, 3);
      chk($sformatf("vec%0d result", i), result, {vt[i].r1, vt[i].r0});
      chk($sformatf("vec%0d ovf", i), {30'd0, ovf_out}, {30'd0, vt[i].ovf});
      step();
    end
    chk("sticky after table", {30'd0, ovf_sticky}, 32'd3);

    run_stream(10, 16'd1, 64'd0, 6, 3, "stall10");
    run_stream(3, 16'd40, 64'h2, 6, 3, "bubble");

    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("sticky clear", {30'd0, ovf_sticky}, 32'd0);
    send_vec(s_ovf, lat);
    step();
    chk("sticky set", {30'd0, ovf_sticky}, 32'd1);
    send_vec(s_ovf, lat);
    chk("sticky beat ovf", {30'd0, ovf_out}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("sticky set wins", {30'd0, ovf_sticky}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("sticky lone clear", {30'd0, ovf_sticky}, 32'd0);

    send_vec(s_ovf, lat);
    step();
    chk("pre-reset sticky", {30'd0, ovf_sticky}, 32'd1);
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      a = {16'h0100, 16'(16'h0100 + 16'(k))};
      b = {16'h0100, 16'h0100};
      step();
    end
    valid_in = 1'b0;
    chk("pre-reset valid_out", {31'd0, valid_out}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid reset valid_out", {31'd0, valid_out}, 32'd0);
    chk("mid reset sticky", {30'd0, ovf_sticky}, 32'd0);
    chk("mid reset result", result, 32'd0);
    chk("mid reset ready_out", {31'd0, ready_out}, 32'd1);
    ready_in = 1'b1;
    lat = 0;
    repeat (6) begin
      if (valid_out) lat++;
      step();
    end
    chk("no stale beats", lat, 0);
    send_vec(vt[0], lat);
    chk("post-reset latency", lat, 3);
    chk("post-reset result", result, {vt[0].r1, vt[0].r0});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
